// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the two-requester pattern-compare arbiter:
// FSM state encoding, default parameter values and the saturating
// counter helper used by the match counter.
package cmp_arbiter_pkg;

  // Legacy-compatible state codes; the enum below is built from them.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    CMP  = S_CMP,
    HOLD = S_HOLD
  } state_e;

  // Default parameter values for the arbiter and its comparator.
  localparam int unsigned  DEF_WIDTH        = 128;
  localparam logic [127:0] DEF_PATTERN      = 128'd8;
  localparam int unsigned  DEF_ALARM_THRESH = 4;

  // Match counter geometry.
  localparam int unsigned CNT_W   = 8;
  localparam logic [7:0]  CNT_MAX = 8'd255;

  // Increment an 8-bit count, holding at the maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage : cmp_arbiter_pkg

// File: rtl/cmp_arbiter_eq_comparator.sv
// Combinational equality check of the latched word against a fixed
// pattern. One instance serves both requesters because only one word is
// ever in flight.
module eq_comparator
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN)
) (
  input  logic [WIDTH-1:0] i_word,
  output logic             o_equal
);

  // Full-width compare; no pipelining, the result is consumed in CMP.
  always_comb begin
    o_equal = 1'b0;
    if (i_word == PATTERN) begin
      o_equal = 1'b1;
    end else begin
      o_equal = 1'b0;
    end
  end

endmodule : eq_comparator

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter feeding a single pattern comparator.
// One word is in flight at a time: IDLE accepts, CMP registers the compare
// result, HOLD presents it until the consumer takes it. A saturating count
// of equal results drives a sticky alarm, both cleared by clr.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN      = WIDTH'(DEF_PATTERN),
  parameter int unsigned      ALARM_THRESH = DEF_ALARM_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_equal,
  input  logic             clr,
  output logic [7:0]       match_cnt,
  output logic             alarm
);

  // Alarm threshold brought to counter width once, so the compare is 8-bit.
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);

  state_e           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_rsp_equal;
  logic [7:0]       r_match_cnt;
  logic             r_alarm;

  logic             w_grant;
  logic             w_any_valid;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_equal;
  logic             w_inc;
  logic [7:0]       w_cnt_next;
  logic             w_alarm_next;

  // Round-robin pick: on a tie the requester that did not win last goes next.
  always_comb begin
    w_grant     = 1'b0;
    w_any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  // Accept only in IDLE and never while reset is being applied.
  always_comb begin
    w_accept   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && (r_state == IDLE)) begin
      w_accept   = w_any_valid;
      req0_ready = req0_valid & ~w_grant;
      req1_ready = req1_valid &  w_grant;
    end else begin
      w_accept   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Steer the granted requester's word toward the data register.
  always_comb begin
    w_sel_data = '0;
    if (w_grant) begin
      w_sel_data = req1_data;
    end else begin
      w_sel_data = req0_data;
    end
  end

  eq_comparator #(
    .WIDTH   (WIDTH),
    .PATTERN (PATTERN)
  ) u_eq_comparator (
    .i_word  (r_data),
    .o_equal (w_equal)
  );

  // Sequence one word through accept, compare and response handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_equal  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data       <= w_sel_data;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= CMP;
          end else begin
            r_state      <= IDLE;
          end
        end
        CMP: begin
          r_rsp_equal <= w_equal;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state     <= HOLD;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Next count and alarm: count equal results as they leave CMP; clr wins.
  always_comb begin
    w_inc        = (r_state == CMP) && w_equal;
    w_cnt_next   = r_match_cnt;
    w_alarm_next = r_alarm;
    if (clr) begin
      w_cnt_next   = 8'd0;
      w_alarm_next = 1'b0;
    end else if (w_inc) begin
      w_cnt_next   = sat_inc8(r_match_cnt);
      w_alarm_next = r_alarm | (sat_inc8(r_match_cnt) >= THRESH_C);
    end else begin
      w_cnt_next   = r_match_cnt;
      w_alarm_next = r_alarm;
    end
  end

  // Register match counter and sticky alarm.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_match_cnt <= 8'd0;
      r_alarm     <= 1'b0;
    end else begin
      r_match_cnt <= w_cnt_next;
      r_alarm     <= w_alarm_next;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_equal = r_rsp_equal;
  assign match_cnt = r_match_cnt;
  assign alarm     = r_alarm;

endmodule : cmp_arbiter

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter. A transaction-level model tracks the
// in-flight word by the cycle its response is due, rather than by FSM state.
module tb_cmp_arbiter;

  localparam int unsigned  W      = 128;
  localparam logic [127:0] PAT    = 128'd8;
  localparam logic [127:0] NOPAT  = 128'd9;
  localparam int unsigned  THRESH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_equal;
  logic         clr;
  logic [7:0]   match_cnt;
  logic         alarm;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   cyc       = 0;
  bit   m_busy    = 1'b0;   // a word has been accepted and not yet handed over
  int   m_due     = 0;      // cycle in which its response first shows
  bit   m_id      = 1'b0;
  bit   m_eq      = 1'b0;
  bit   m_last    = 1'b1;
  bit   m_rsp_id  = 1'b0;
  bit   m_rsp_eq  = 1'b0;
  int   m_cnt     = 0;
  bit   m_alarm   = 1'b0;

  cmp_arbiter #(
    .WIDTH        (W),
    .PATTERN      (PAT),
    .ALARM_THRESH (THRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_equal  (rsp_equal),
    .clr        (clr),
    .match_cnt  (match_cnt),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance model.
  task automatic step(input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1,
                      input logic rr, input logic c, input logic rn);
    bit g, e_r0, e_r1, e_rv;
    int nc;
    bit na;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    rsp_ready  = rr; clr = c; rst_n = rn;
    #1;
    g    = (v0 && v1) ? ~m_last : v1;
    e_r0 = rn && !m_busy && v0 && !g;
    e_r1 = rn && !m_busy && v1 && g;
    e_rv = m_busy && (cyc >= m_due);
    check("req0_ready", {7'd0, req0_ready}, {7'd0, e_r0});
    check("req1_ready", {7'd0, req1_ready}, {7'd0, e_r1});
    check("rsp_valid",  {7'd0, rsp_valid},  {7'd0, e_rv});
    check("rsp_id",     {7'd0, rsp_id},     {7'd0, m_rsp_id});
    check("rsp_equal",  {7'd0, rsp_equal},  {7'd0, m_rsp_eq});
    check("match_cnt",  match_cnt,          8'(m_cnt));
    check("alarm",      {7'd0, alarm},      {7'd0, m_alarm});
    @(posedge clk);
    if (!rn) begin
      m_busy = 1'b0; m_last = 1'b1; m_rsp_id = 1'b0; m_rsp_eq = 1'b0;
      m_cnt = 0; m_alarm = 1'b0;
    end else begin
      nc = m_cnt; na = m_alarm;
      if (m_busy && (cyc == m_due - 1)) begin
        m_rsp_id = m_id; m_rsp_eq = m_eq;
        if (m_eq && m_cnt < 255) nc = m_cnt + 1;
        if (nc >= THRESH) na = 1'b1;
      end
      if (c) begin nc = 0; na = 1'b0; end
      m_cnt = nc; m_alarm = na;
      if (e_rv && rr) begin
        m_busy = 1'b0;
      end else if (e_r0 || e_r1) begin
        m_busy = 1'b1; m_due = cyc + 2; m_id = g; m_last = g;
        m_eq = ((g ? d1 : d0) == PAT);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_word();
    int unsigned sel;
    sel = $urandom_range(0, 2);
    if (sel == 0) return PAT;
    if (sel == 1) return NOPAT;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] zero;
    zero = '0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = zero; req1_data = zero;
    rsp_ready = 1'b0; clr = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, and readies held low while reset is applied
    step(1'b1, PAT, 1'b1, PAT, 1'b1, 1'b0, 1'b0);
    step(1'b0, zero, 1'b0, zero, 1'b0, 1'b0, 1'b1);

    // Single matching word from requester 0
    step(1'b1, PAT, 1'b0, zero, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, zero, 1'b0, zero, 1'b1, 1'b0, 1'b1);
    check("single_cnt", match_cnt, 8'd1);

    // Both requesting continuously: alternating grants, 1/0 results
    repeat (12) step(1'b1, PAT, 1'b1, NOPAT, 1'b1, 1'b0, 1'b1);

    // Consumer stalls: response held, no new accept
    repeat (8) step(1'b1, PAT, 1'b1, NOPAT, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, PAT, 1'b1, NOPAT, 1'b1, 1'b0, 1'b1);

    // Alarm on fourth match; clr coincident with the fifth increment
    step(1'b0, zero, 1'b0, zero, 1'b1, 1'b1, 1'b1);
    while (m_busy) step(1'b0, zero, 1'b0, zero, 1'b1, 1'b1, 1'b1);
    step(1'b0, zero, 1'b0, zero, 1'b1, 1'b1, 1'b1);
    repeat (12) step(1'b1, PAT, 1'b0, zero, 1'b1, 1'b0, 1'b1);
    check("alarm_at_4", {7'd0, alarm}, 8'd1);
    for (int i = 0; i < 4; i++)
      step(1'b1, PAT, 1'b0, zero, 1'b1,
           (m_busy && (cyc == m_due - 1)) ? 1'b1 : 1'b0, 1'b1);
    check("clr_cnt", match_cnt, 8'd0);
    check("clr_alarm", {7'd0, alarm}, 8'd0);

    // Reset while holding a response; next tie goes to requester 0
    while (!(m_busy && cyc >= m_due))
      step(1'b1, PAT, 1'b0, zero, 1'b0, 1'b0, 1'b1);
    step(1'b0, zero, 1'b0, zero, 1'b0, 1'b0, 1'b0);
    check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    step(1'b1, NOPAT, 1'b1, PAT, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, zero, 1'b0, zero, 1'b1, 1'b0, 1'b1);

    // Saturation after 300 matches
    step(1'b0, zero, 1'b0, zero, 1'b1, 1'b1, 1'b1);
    repeat (905) step(1'b1, PAT, 1'b1, PAT, 1'b1, 1'b0, 1'b1);
    check("sat_cnt", match_cnt, 8'd255);
    check("sat_alarm", {7'd0, alarm}, 8'd1);

    // Random traffic, occasional clr and reset
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_word(),
           $urandom_range(0, 3) != 0, rand_word(),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 80) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cmp_arbiter

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter WIDTH, 128, compared word width in bits.
REQ-002 Parameter PATTERN, 128'd8, match constant applied by the comparator.
REQ-003 Parameter ALARM_THRESH, 4, match count at which alarm sets (1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 req0_valid  input  1  requester 0 has a word to check.
REQ-007 req0_data  input  WIDTH  requester 0 word.
REQ-008 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-009 req1_valid  input  1  requester 1 has a word to check.
REQ-010 req1_data  input  WIDTH  requester 1 word.
REQ-011 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer takes result.
REQ-014 rsp_id  output  1  requester index of current result.
REQ-015 rsp_equal  output  1  1 when accepted word == PATTERN.
REQ-016 clr  input  1  clears match_cnt and alarm.
REQ-017 match_cnt  output  8  saturating count of equal results.
REQ-018 alarm  output  1  sticky flag, set when match_cnt >= ALARM_THRESH.

Function
REQ-019 FSM states SHALL be IDLE, CMP, HOLD.
REQ-020 IDLE: if any reqN_valid, grant one, latch its data and id, assert that reqN_ready for exactly that cycle, go to CMP; else stay.
REQ-021 Arbitration SHALL be round-robin on last_grant: both valid -> grant requester != last_grant; one valid -> grant it; last_grant updates on every accept.
REQ-022 reqN_ready SHALL be combinational: (state==IDLE) && reqN_valid && grant==N; never asserted outside IDLE; never both at once.
REQ-023 CMP: register comparator output into rsp_equal, latched id into rsp_id, set rsp_valid, go to HOLD; lasts exactly one cycle.
REQ-024 HOLD: rsp_valid=1 with rsp_id/rsp_equal stable until rsp_ready=1; on that cycle clear rsp_valid, go to IDLE.
REQ-025 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; minimum issue interval 3 cycles.
REQ-026 Requesters SHALL hold reqN_data stable while reqN_valid and not ready; the block samples data only at accept.
REQ-027 match_cnt SHALL increment by 1 on CMP->HOLD when the result is equal, saturating at 255.
REQ-028 alarm SHALL set on the cycle match_cnt becomes >= ALARM_THRESH and remain set until clr or reset.
REQ-029 clr SHALL zero match_cnt and alarm next cycle; clr coincident with an increment -> result 0, alarm 0 (clr wins).
REQ-030 clr SHALL NOT affect FSM, arbitration or rsp_* outputs.
REQ-031 A requester withdrawing valid before grant is permitted and SHALL NOT be accepted.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force: state IDLE, last_grant=1 (requester 0 wins first tie), rsp_valid=0, rsp_id=0, rsp_equal=0, match_cnt=0, alarm=0.
REQ-033 Reset mid-operation (CMP or HOLD) SHALL drop the in-flight word; no response is emitted for it.
REQ-034 reqN_ready SHALL be 0 while rst_n=0.

Structure
REQ-035 Shared package SHALL hold the state enum (IDLE, CMP, HOLD), default WIDTH, default PATTERN, default ALARM_THRESH.
REQ-036 One sub-module, eq_comparator: combinational WIDTH-bit equality of latched word against PATTERN; single instance shared by both requesters.
REQ-037 No other sub-modules; arbiter, FSM and counter are in cmp_arbiter.

Verification
REQ-038 req0_valid, data=8, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid cycle 2 with rsp_id=0, rsp_equal=1, match_cnt=1.
REQ-039 Both valid continuously, data0=8, data1=9, rsp_ready=1 -> grants alternate 0,1,0,1 every 3 cycles; rsp_equal alternates 1,0.
REQ-040 rsp_ready held 0 for 5 cycles after result -> rsp_valid/rsp_id/rsp_equal stable, both ready 0, no new accept until handshake.
REQ-041 Four matches with ALARM_THRESH=4 -> alarm rises on the 4th CMP->HOLD; clr pulse coincident with a 5th match -> match_cnt=0, alarm=0.
REQ-042 rst_n=0 asserted in HOLD -> next cycle rsp_valid=0, match_cnt=0, state IDLE; first subsequent tie grants requester 0.
REQ-043 300 consecutive matches -> match_cnt saturates at 255, alarm remains 1.
